dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 172 +++++++++++++++++
 tb/tb_dmem_resp.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: single-port 32-bit word memory behind a req/ack handshake with fixed wait states.
// Latency: ack pulses WAIT+1 cycles after the accept edge; one access in flight at a time.
// Backpressure: req is sampled only in IDLE; requests while busy are dropped, not queued.
// Optional feature: define DMEM_ERR_EN for address range checking and the err output.
module dmem_resp #(
   parameter int DEPTH = 64,
   parameter int WAIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy
`ifdef DMEM_ERR_EN
   ,
   output logic        err
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [3:0]     cnt;
   logic [3:0]     cnt_nxt;
   logic           accept;
   logic           enter_resp;

   // captured request, held for the whole access
   logic           we_q;
   logic [AW-1:0]  idx_q;
   logic [31:0]    wdata_q;
   logic [3:0]     be_q;
   logic           bad_q;

   // request seen by the commit logic: live inputs in IDLE (WAIT=0 commits on the accept edge)
   logic           cur_we;
   logic [AW-1:0]  cur_idx;
   logic [31:0]    cur_wdata;
   logic [3:0]     cur_be;
   logic           cur_bad;
   logic           live_bad;

   logic [31:0]    mem [DEPTH];

`ifdef DMEM_ERR_EN
   // misaligned or beyond the array: acked on schedule but never touches memory
   assign live_bad = (addr[31:AW+2] != '0) || (addr[1:0] != 2'b00);
   assign err      = (state == S_RESP) && bad_q;
`else
   // without range checking the upper and low address bits are don't-care; index wraps
   logic unused_addr;
   assign live_bad    = 1'b0;
   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
`endif

   assign ack  = (state == S_RESP);
   assign busy = (state != S_IDLE);

   // next-state and countdown logic
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      accept     = 1'b0;
      enter_resp = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (WAIT == 0) begin
                  state_nxt  = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt  = S_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_RESP: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // select live inputs on the accept edge, captured copies afterwards
   always_comb begin
      cur_we    = we_q;
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
      cur_bad   = bad_q;
      if (state == S_IDLE) begin
         cur_we    = we;
         cur_idx   = addr[AW+1:2];
         cur_wdata = wdata;
         cur_be    = be;
         cur_bad   = live_bad;
      end
   end

   // state register and countdown
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // capture the request on accept so later input changes cannot disturb it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         bad_q   <= 1'b0;
      end else if (accept) begin
         we_q    <= we;
         idx_q   <= addr[AW+1:2];
         wdata_q <= wdata;
         be_q    <= be;
         bad_q   <= live_bad;
      end
   end

   // read data loads on the edge entering RESP and holds until the next read ack
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= 32'd0;
      end else if (enter_resp) begin
         if (cur_bad) begin
            rdata <= 32'd0;
         end else if (!cur_we) begin
            rdata <= mem[cur_idx];
         end
      end
   end

   // byte-masked write commit on the edge entering RESP; array itself is never reset
   always_ff @(posedge clk) begin
      if (enter_resp && reset && cur_we && !cur_bad) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_be[i]) begin
               mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed plus randomized checks of dmem_resp against a word-array model.
// Two instances: WAIT=2 (index 0) and WAIT=0 (index 1), DEPTH=64.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_dmem_resp;

   localparam int DEPTH = 64;
   localparam int W0    = 2;
   localparam int W1    = 0;

   logic        clk;
   logic        rst_n [2];
   logic        req   [2];
   logic        we    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  be    [2];
   logic [31:0] rdata [2];
   logic        ack   [2];
   logic        busy  [2];
   logic        err   [2];

   int total = 0;
   int bad   = 0;

   logic [31:0] model  [2][DEPTH];
   logic [31:0] last_r [2];

   dmem_resp #(.DEPTH(DEPTH), .WAIT(W0)) u0 (
      .clk(clk), .reset(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
      .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0])
`ifdef DMEM_ERR_EN
      , .err(err[0])
`endif
   );

   dmem_resp #(.DEPTH(DEPTH), .WAIT(W1)) u1 (
      .clk(clk), .reset(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
      .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1])
`ifdef DMEM_ERR_EN
      , .err(err[1])
`endif
   );

`ifndef DMEM_ERR_EN
   assign err[0] = 1'b0;
   assign err[1] = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // One complete access; called at a falling edge with the DUT idle, returns at a falling edge idle.
   task automatic access(input int d, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b);
      int          wt;
      int          idx;
      bit          bad_a;
      logic [31:0] word;
      wt  = (d == 0) ? W0 : W1;
      idx = int'((a >> 2) % DEPTH);
`ifdef DMEM_ERR_EN
      bad_a = (a >= 32'(DEPTH * 4)) || (a[1:0] != 2'b00);
`else
      bad_a = 1'b0;
`endif
      req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
      @(posedge clk);
      #1;
      // scramble inputs after accept; the access in flight must not notice
      req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom;
      wdata[d] = $urandom; be[d] = 4'($urandom);
      if (bad_a) begin
         last_r[d] = 32'd0;
      end else if (w) begin
         word = model[d][idx];
         for (int i = 0; i < 4; i++)
            if (b[i]) word[8*i +: 8] = wd[8*i +: 8];
         model[d][idx] = word;
      end else begin
         last_r[d] = model[d][idx];
      end
      for (int k = 1; k <= wt + 2; k++) begin
         @(negedge clk);
         check("ack", 32'(ack[d]), 32'(k == wt + 1));
         check("busy", 32'(busy[d]), 32'(k <= wt + 1));
`ifdef DMEM_ERR_EN
         check("err", 32'(err[d]), 32'((k == wt + 1) && bad_a));
`endif
         if (k >= wt + 1) check("rdata", rdata[d], last_r[d]);
      end
   endtask

   initial begin
      logic [31:0] a;
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0;
         wdata[d] = 32'd0; be[d] = 4'd0; last_r[d] = 32'd0;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_ack", 32'(ack[d]), 32'd0);
         check("rst_busy", 32'(busy[d]), 32'd0);
         check("rst_rdata", rdata[d], 32'd0);
         check("rst_err", 32'(err[d]), 32'd0);
      end
      repeat (2) @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      // fill both memories so every later read has a known value
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++)
            access(d, 1'b1, 32'(i * 4), $urandom, 4'hF);

      // full write, read back, byte-masked merge
      access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
      access(0, 1'b0, 32'h10, 32'h0, 4'h0);
      check("rd_deadbeef", rdata[0], 32'hDEADBEEF);
      @(negedge clk);
      check("rd_held", rdata[0], 32'hDEADBEEF);
      access(0, 1'b1, 32'h10, 32'h11223344, 4'b0101);
      check("wr_keeps_rdata", rdata[0], 32'hDEADBEEF);
      access(0, 1'b0, 32'h10, 32'h0, 4'h0);
      check("rd_merged", rdata[0], 32'hDE22BE44);
      access(0, 1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000);
      access(0, 1'b0, 32'h14, 32'h0, 4'h0);

      // reset in the wait phase of a write drops it
      access(0, 1'b1, 32'h20, 32'h00000000, 4'hF);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
      @(posedge clk);
      #1;
      req[0] = 1'b0;
      @(negedge clk);
      check("mid_busy", 32'(busy[0]), 32'd1);
      rst_n[0] = 1'b0;
      #1;
      check("abort_busy", 32'(busy[0]), 32'd0);
      check("abort_ack", 32'(ack[0]), 32'd0);
      check("abort_rdata", rdata[0], 32'd0);
      last_r[0] = 32'd0;
      @(negedge clk);
      rst_n[0] = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("no_ack_after_abort", 32'(ack[0]), 32'd0);
      end
      access(0, 1'b0, 32'h20, 32'h0, 4'h0);
      check("rd_after_abort", rdata[0], 32'h00000000);

      // out-of-range address: err build flags it, default build aliases word 0
      access(0, 1'b0, 32'h100, 32'h0, 4'h0);

      // WAIT=0 with req held high: ack every other cycle
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; wdata[1] = 32'h0; be[1] = 4'h0;
      check("b2b_pre", 32'(ack[1]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("b2b_ack", 32'(ack[1]), 32'(k != 1));
         if (k != 1) check("b2b_rdata", rdata[1], model[1][4]);
      end
      req[1] = 1'b0;
      @(negedge clk);
      check("b2b_end_ack", 32'(ack[1]), 32'd0);
      check("b2b_end_busy", 32'(busy[1]), 32'd0);
      last_r[1] = model[1][4];

      // randomized traffic on both instances
      for (int n = 0; n < 60; n++) begin
         for (int d = 0; d < 2; d++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = 32'($urandom_range(0, DEPTH - 1) * 4);
            access(d, 1'($urandom), a, $urandom, 4'($urandom));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
